// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared RV32I memory-stage definitions: funct3 access-size
//                codes, LSU state encoding and size-decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // Byte accesses are 000/100; halves are 001/101; everything else is a word.
    function automatic logic f3_is_byte(input logic [2:0] f3);
        return (f3[1:0] == 2'b00);
    endfunction

    function automatic logic f3_is_half(input logic [2:0] f3);
        return (f3[1:0] == 2'b01);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_load_extend
//  Description : Selects the addressed byte/half lane of a 32-bit bus word and
//                sign- or zero-extends it according to funct3.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_extend
    import rv_pkg::*;
(
    input  logic [2:0]  f3,
    input  logic [1:0]  lane,
    input  logic [31:0] bus_rdata,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by width-dependent extension; unknown sizes pass the word.
    always_comb begin
        byte_sel = bus_rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3)
            F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ext_data = {24'h000000, byte_sel};
            F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ext_data = {16'h0000, half_sel};
            default: ext_data = bus_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Memory-stage LSU. Registers one load/store request, runs a
//                req/ack transaction on the data bus, returns the extended
//                load result and stalls the pipeline until completion.
//                Optional macro MISALIGN_CHECK_EN adds a misalignment trap
//                (port misalign) that completes without a bus request.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import rv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [2:0]        f3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              stall,
    output logic              done,
    output logic              busReq,
    output logic              busWe,
    output logic [ADDR_W-1:0] busAddr,
    output logic [DATA_W-1:0] busWdata,
    output logic [3:0]        busBe,
`ifdef MISALIGN_CHECK_EN
    output logic              misalign,
`endif
    input  logic              busAck,
    input  logic [DATA_W-1:0] busRdata
);

    lsu_state_e        state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lane_q, lane_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic              bus_req_q, bus_req_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [DATA_W-1:0] ext_data;
    logic [3:0]        store_be;
    logic [DATA_W-1:0] store_wdata;
`ifdef MISALIGN_CHECK_EN
    logic              misalign_q, misalign_d;
    logic              misaligned;
`endif

    lsu_load_extend u_load_extend (
        .f3        (f3_q),
        .lane      (lane_q),
        .bus_rdata (busRdata),
        .ext_data  (ext_data)
    );

    // Store lane steering: replicate data across the word and enable the addressed bytes.
    always_comb begin
        if (f3_is_byte(f3)) begin
            store_be    = 4'b0001 << addr[1:0];
            store_wdata = {4{writeData[7:0]}};
        end else if (f3_is_half(f3)) begin
            store_be    = addr[1] ? 4'b1100 : 4'b0011;
            store_wdata = {2{writeData[15:0]}};
        end else begin
            store_be    = 4'b1111;
            store_wdata = writeData;
        end
    end

`ifdef MISALIGN_CHECK_EN
    // A half must sit on an even address, a word on a 4-byte boundary.
    always_comb begin
        misaligned = f3_is_half(f3) ? addr[0]
                   : (!f3_is_byte(f3) && (addr[1:0] != 2'b00));
    end
`endif

    // Next-state and next-output logic for the IDLE -> BUS -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        we_d        = we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        bus_req_d   = 1'b0;
        done_d      = 1'b0;
        read_data_d = read_data_q;
`ifdef MISALIGN_CHECK_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (memWrite || memRead) begin
                    we_d        = memWrite;
                    f3_d        = f3;
                    lane_d      = addr[1:0];
                    bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    bus_wdata_d = store_wdata;
                    bus_be_d    = memWrite ? store_be : 4'b1111;
`ifdef MISALIGN_CHECK_EN
                    if (misaligned) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        state_d   = BUS;
                        bus_req_d = 1'b1;
                    end
`else
                    state_d   = BUS;
                    bus_req_d = 1'b1;
`endif
                end
            end
            BUS: begin
                if (busAck) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        read_data_d = ext_data;
                    end
                end else begin
                    bus_req_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            f3_q        <= '0;
            lane_q      <= '0;
            we_q        <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            bus_req_q   <= 1'b0;
            done_q      <= 1'b0;
            read_data_q <= '0;
`ifdef MISALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            we_q        <= we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            bus_req_q   <= bus_req_d;
            done_q      <= done_d;
            read_data_q <= read_data_d;
`ifdef MISALIGN_CHECK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign stall    = (memRead || memWrite) && (state_q != DONE);
    assign readData = read_data_q;
    assign done     = done_q;
    assign busReq   = bus_req_q;
    assign busWe    = we_q;
    assign busAddr  = bus_addr_q;
    assign busWdata = bus_wdata_q;
    assign busBe    = bus_be_q;
`ifdef MISALIGN_CHECK_EN
    assign misalign = misalign_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed scoreboard bench for load_store_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite;
    logic [2:0]  f3;
    logic [31:0] addr, writeData, readData;
    logic        stall, done, busReq, busWe;
    logic [31:0] busAddr, busWdata;
    logic [3:0]  busBe;
    logic        busAck;
    logic [31:0] busRdata;
`ifdef MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .f3        (f3),
        .addr      (addr),
        .writeData (writeData),
        .readData  (readData),
        .stall     (stall),
        .done      (done),
        .busReq    (busReq),
        .busWe     (busWe),
        .busAddr   (busAddr),
        .busWdata  (busWdata),
        .busBe     (busBe),
`ifdef MISALIGN_CHECK_EN
        .misalign  (misalign),
`endif
        .busAck    (busAck),
        .busRdata  (busRdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One request held until done; expected bus view and load result come from the caller.
    task automatic access(input logic rd, input logic wr, input logic [2:0] fv,
                          input logic [31:0] a, input logic [31:0] wd, input int waits,
                          input logic [31:0] rdata, input logic [31:0] e_addr,
                          input logic [3:0] e_be, input logic [31:0] e_wdata,
                          input logic [31:0] e_rd);
        exp_t e;
        int   n_bus  = 0;
        int   n_stl  = 0;
        bit   got    = 0;
        bit   fin    = 0;
        exp_q.push_back('{wr, e_addr, e_be, e_wdata, e_rd});
        @(posedge clk); #1;
        memRead = rd; memWrite = wr; f3 = fv; addr = a; writeData = wd;
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            @(negedge clk);
            if (stall) n_stl++;
            if (done) begin
                fin = 1;
            end else if (busReq) begin
                if (!got) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                    end
                    got = 1;
                end
                chk("busAddr", busAddr, e.addr);
                chk("busBe", {28'd0, busBe}, {28'd0, e.be});
                chk("busWe", {31'd0, busWe}, {31'd0, e.we});
                if (e.we) chk("busWdata", busWdata, e.wdata);
                n_bus++;
                if (n_bus > waits) begin
                    busAck = 1'b1; busRdata = rdata;
                end
            end
        end
        busAck = 1'b0;
        if (!fin) chk("done_timeout", 32'd0, 32'd1);
        chk("saw_busReq", {31'd0, got}, 32'd1);
        chk("readData", readData, e_rd);
        chk("stall_cycles", n_stl, waits + 2);
        memRead = 1'b0; memWrite = 1'b0;
        @(negedge clk);
        chk("done_one_pulse", {31'd0, done}, 32'd0);
        chk("busReq_after", {31'd0, busReq}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; memRead = 0; memWrite = 0; f3 = 0; addr = 0; writeData = 0;
        busAck = 0; busRdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_readData", readData, 32'd0);
        chk("rst_busReq", {31'd0, busReq}, 32'd0);
        chk("rst_busWe", {31'd0, busWe}, 32'd0);
        chk("rst_busAddr", busAddr, 32'd0);
        chk("rst_busWdata", busWdata, 32'd0);
        chk("rst_busBe", {28'd0, busBe}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;

        // rd wr f3 addr wd waits rdata | busAddr be wdata readData
        access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 32'h0, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0);
        access(0, 1, 3'b000, 32'h13, 32'h000000A5, 0, 32'h0, 32'h10, 4'b1000, 32'hA5A5A5A5, 32'h0);
        access(0, 1, 3'b001, 32'h12, 32'h1234BEEF, 1, 32'h0, 32'h10, 4'b1100, 32'hBEEFBEEF, 32'h0);
        access(1, 0, 3'b000, 32'h22, 32'h0, 1, 32'h00800000, 32'h20, 4'b1111, 32'h0, 32'hFFFFFF80);
        access(1, 0, 3'b100, 32'h22, 32'h0, 0, 32'h00800000, 32'h20, 4'b1111, 32'h0, 32'h00000080);
        access(1, 0, 3'b001, 32'h06, 32'h0, 0, 32'h80011234, 32'h04, 4'b1111, 32'h0, 32'hFFFF8001);
        access(1, 0, 3'b101, 32'h06, 32'h0, 2, 32'h80011234, 32'h04, 4'b1111, 32'h0, 32'h00008001);
        access(1, 0, 3'b010, 32'h08, 32'h0, 2, 32'h12345678, 32'h08, 4'b1111, 32'h0, 32'h12345678);
        access(1, 0, 3'b011, 32'h0C, 32'h0, 0, 32'hCAFEF00D, 32'h0C, 4'b1111, 32'h0, 32'hCAFEF00D);
        // both requests raised: write wins and readData is untouched
        access(1, 1, 3'b010, 32'h20, 32'h11223344, 0, 32'h0, 32'h20, 4'b1111, 32'h11223344, 32'hCAFEF00D);

        // ack while idle is ignored
        @(negedge clk); busAck = 1'b1; busRdata = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        chk("idle_ack_done", {31'd0, done}, 32'd0);
        chk("idle_ack_busReq", {31'd0, busReq}, 32'd0);
        chk("idle_ack_readData", readData, 32'hCAFEF00D);
        busAck = 1'b0;

`ifdef MISALIGN_CHECK_EN
        @(posedge clk); #1;
        memRead = 1'b1; f3 = 3'b010; addr = 32'h05;
        @(negedge clk);
        chk("mis_busReq1", {31'd0, busReq}, 32'd0);
        chk("mis_done1", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("mis_done2", {31'd0, done}, 32'd1);
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_busReq2", {31'd0, busReq}, 32'd0);
        chk("mis_readData", readData, 32'hCAFEF00D);
        memRead = 1'b0;
        @(negedge clk);
        chk("mis_done3", {31'd0, done}, 32'd0);
        chk("mis_flag3", {31'd0, misalign}, 32'd0);
`else
        // without the check, a half uses addr[1] and a word ignores addr[1:0]
        access(1, 0, 3'b001, 32'h03, 32'h0, 0, 32'hABCD0000, 32'h00, 4'b1111, 32'h0, 32'hFFFFABCD);
        access(1, 0, 3'b010, 32'h05, 32'h0, 1, 32'h55667788, 32'h04, 4'b1111, 32'h0, 32'h55667788);
`endif

        // reset in BUS with no ack abandons the access
        @(posedge clk); #1;
        memRead = 1'b1; f3 = 3'b010; addr = 32'h40;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busReq", {31'd0, busReq}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busReq", {31'd0, busReq}, 32'd0);
        chk("mid_rst_readData", readData, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_busAddr", busAddr, 32'd0);
        rst = 1'b0; memRead = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_done", {31'd0, done}, 32'd0);
            chk("post_rst_busReq", {31'd0, busReq}, 32'd0);
        end
        access(1, 0, 3'b100, 32'h01, 32'h0, 0, 32'h00007F00, 32'h00, 4'b1111, 32'h0, 32'h0000007F);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the datapath.
- Takes the ALU result as the effective address, the store data and funct3. Runs a req/ack transaction on a variable-latency data-memory bus.
- Returns a sign- or zero-extended `readData` to the datapath's writeback mux.
- Raises `stall` to freeze the PC and register-file write until the access completes.

Parameters:
- `ADDR_W`, 32, width of the effective address and `busAddr`.
- `DATA_W`, 32, bus data width; fixed at 32 for RV32I lane logic.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `memRead`  in  1  load request from control; held high until `done`.
- `memWrite`  in  1  store request from control; held high until `done`.
- `f3`  in  3  instruction funct3 (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
- `addr`  in  ADDR_W  effective address (datapath `aluRes`).
- `writeData`  in  32  store data (rs2).
- `readData`  out  32  extended load result.
- `stall`  out  1  high while a request is pending and not yet done.
- `done`  out  1  one-cycle completion pulse.
- `busReq`  out  1  bus request.
- `busWe`  out  1  1 = write.
- `busAddr`  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- `busWdata`  out  32  lane-replicated store data.
- `busBe`  out  4  byte enables.
- `busAck`  in  1  bus completion; read data valid the same cycle.
- `busRdata`  in  32  bus read data.

Behaviour:
- Reset: synchronous, active-high; `clk` single clock domain. State goes to IDLE.
  - `readData`=0, `busReq`=0, `busWe`=0, `busAddr`=0, `busWdata`=0, `busBe`=0, `done`=0.
  - A reset mid-transaction abandons it: `busReq` drops the next edge and no `done` is issued.
- FSM: IDLE -> BUS -> DONE -> IDLE.
- IDLE:
  - If `memWrite` or `memRead`, register addr, f3, lanes, data and `we`, then go to BUS.
  - If both are asserted, the write wins.
- BUS:
  - `busReq`=1; all bus outputs are stable from registers.
  - Stay in BUS while `busAck`=0.
  - On `busAck`=1: capture the load result into `readData` (reads only) and go to DONE.
- DONE:
  - `done`=1 for one cycle, `busReq`=0, then IDLE.
- `stall` = (`memRead`|`memWrite`) & (state != DONE), combinational.
  - Best case is 2 stall cycles (ack in the first BUS cycle).
  - A new request is seen in the IDLE cycle after DONE; no back-to-back bus cycles without IDLE.
- Store lanes:
  - SB: `busBe` = 1<<addr[1:0]; `busWdata` = {4{wd[7:0]}}.
  - SH: `busBe` = addr[1] ? 1100 : 0011; `busWdata` = {2{wd[15:0]}}.
  - SW: `busBe` = 1111; `busWdata` = wd.
- Load extract:
  - Byte lane is addr[1:0]; half lane is addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Loads drive `busBe` = 1111.
- Undefined f3 (011, 110, 111) is treated as word.
- `readData` holds its value until the next completed load; stores do not modify it.
- `busAck` outside BUS is ignored.

Optional Feature:
- Macro: `MISALIGN_CHECK_EN`.
- Defined:
  - Adds port `misalign` out 1.
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, takes IDLE -> DONE directly with no bus request.
  - `misalign`=1 together with `done`; `readData` is unchanged.
- Undefined:
  - No port and no check.
  - Low address bits beyond lane selection are ignored: a half uses addr[1]; a word is treated as aligned.

Decomposition:
- Shared package `rv_pkg`:
  - funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - LSU state encoding (IDLE, BUS, DONE).
- One natural sub-module: `lsu_load_extend`, combinational. Inputs f3, addr[1:0], busRdata; output the extended 32-bit value.

Test Plan:
- SW addr=0x0000_0010, wd=0xDEADBEEF, ack after 3 wait cycles -> `busAddr`=0x10, `busBe`=1111, `busWdata`=0xDEADBEEF held stable; `done` pulses once; `stall` high 5 cycles.
- SB addr=0x13, wd=0x0000_00A5, ack immediate -> `busBe`=1000, `busWdata`=0xA5A5A5A5, `busAddr`=0x10.
- LB addr=0x22, rdata=0x0080_0000 -> `readData`=0xFFFFFF80; LBU with the same inputs -> 0x00000080.
- LH addr=0x06, rdata=0x8001_1234 -> `readData`=0xFFFF8001; LHU -> 0x00008001.
- `rst` asserted while in BUS with `busAck`=0 -> next cycle `busReq`=0, state IDLE, `readData`=0, no `done`.
- (`MISALIGN_CHECK_EN`) LW addr=0x05 -> no `busReq`; `done`=1 and `misalign`=1 in the second cycle; `readData` unchanged.
